// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-N stream demultiplexer.
package demux_pkg;

    localparam int DROP_CNT_W = 16;
    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/demux_out_slot.sv
// One-entry valid/ready holding register for a single demux output channel.
//   state | meaning
//   EMPTY | no beat held, out_valid low, out_data driven to zero
//   FULL  | beat held in data_q, presented until out_ready
module demux_out_slot
    import demux_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              free
);

    slot_state_e       state, state_nxt;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= EMPTY;
            data_q <= '0;
        end else begin
            state <= state_nxt;
            if (wr_en) data_q <= wr_data;
        end
    end

    // A write in the same cycle as a drain keeps the slot FULL with the new beat.
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (wr_en) state_nxt = FULL;
            FULL: begin
                if (wr_en)          state_nxt = FULL;
                else if (out_ready) state_nxt = EMPTY;
            end
            default: state_nxt = EMPTY;
        endcase
    end

    assign out_valid = (state == FULL);
    assign out_data  = (state == FULL) ? data_q : '0;
    assign free      = (state == EMPTY) | out_ready;

endmodule

// File: rtl/demux_1_to_n_stream.sv
// Registered 1-to-N stream demux: unicast by in_sel, broadcast to all slots,
// out-of-range selects are accepted, dropped and counted.
module demux_1_to_n_stream
    import demux_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int N_OUT  = 4,
    localparam int SEL_W  = $clog2(N_OUT)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_bcast,
    output logic [N_OUT-1:0]        out_valid,
    input  logic [N_OUT-1:0]        out_ready,
    output logic [N_OUT*DATA_W-1:0] out_data,
    output logic                    err_sel,
    output logic [DROP_CNT_W-1:0]   drop_cnt
);

    logic [N_OUT-1:0] free;
    logic [N_OUT-1:0] wr;
    logic             sel_ok;
    logic             drop;

    generate
        if (N_OUT == (1 << SEL_W)) begin : g_sel_full
            assign sel_ok = 1'b1;
        end else begin : g_sel_range
            assign sel_ok = (in_sel < SEL_W'(N_OUT));
        end
    endgenerate

    // Broadcast waits for every slot so no channel ever sees a partial copy.
    always_comb begin
        in_ready = 1'b0;
        wr       = '0;
        drop     = 1'b0;
        if (in_bcast) begin
            in_ready = &free;
            if (in_valid && in_ready) wr = '1;
        end else if (sel_ok) begin
            in_ready   = free[in_sel];
            wr[in_sel] = in_valid & free[in_sel];
        end else begin
            in_ready = 1'b1;
            drop     = in_valid;
        end
        if (!rst_n) begin
            in_ready = 1'b0;
            wr       = '0;
            drop     = 1'b0;
        end
    end

    generate
        for (genvar k = 0; k < N_OUT; k++) begin : g_slot
            demux_out_slot #(.DATA_W(DATA_W)) u_slot (
                .clk       (clk),
                .rst_n     (rst_n),
                .wr_en     (wr[k]),
                .wr_data   (in_data),
                .out_ready (out_ready[k]),
                .out_valid (out_valid[k]),
                .out_data  (out_data[k*DATA_W +: DATA_W]),
                .free      (free[k])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sel  <= 1'b0;
            drop_cnt <= '0;
        end else begin
            err_sel <= drop;
            if (drop && (drop_cnt != DROP_CNT_MAX))
                drop_cnt <= drop_cnt + DROP_CNT_W'(1);
        end
    end

endmodule
